// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath. It sequences each instruction,
// counts retired instructions and pulses illegal_op on unsupported opcodes.
module multicycle_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             aluop1,
  output logic             aluop0,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;

  state_t cur_state, next_state;

  logic pc_write_raw, pc_write_cond_raw, mem_read_raw, mem_write_raw;
  logic ir_write_raw, reg_write_raw, instr_done_raw, illegal_op_raw;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= next_state;
  end

  // Every done state returns to FETCH, so the edge leaving it retires the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              instr_count <= '0;
    else if (instr_done_raw) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    next_state        = S_FETCH;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    instr_done_raw    = 1'b0;
    illegal_op_raw    = 1'b0;
    i_or_d            = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    pc_source         = 2'b00;
    aluop             = 2'b00;
    case (cur_state)
      S_FETCH: begin
        next_state   = S_DECODE;
        mem_read_raw = 1'b1;
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_src_b    = 2'b01;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ORI:       next_state = S_ORIEX;
          default: begin
            next_state     = S_FETCH;
            illegal_op_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      next_state = S_MEMRD;
        else if (opcode == OP_SW) next_state = S_MEMWR;
        else                      next_state = S_FETCH;
      end
      S_MEMRD: begin
        next_state   = S_MEMWB;
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg     = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw  = 1'b1;
        i_or_d         = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_EXEC: begin
        next_state = S_RWB;
        alu_src_a  = 1'b1;
        aluop      = 2'b10;
      end
      S_RWB: begin
        reg_write_raw  = 1'b1;
        reg_dst        = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        aluop             = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
        instr_done_raw    = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw   = 1'b1;
        pc_source      = 2'b10;
        instr_done_raw = 1'b1;
      end
      S_ORIEX: begin
        next_state = S_ORIWB;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        aluop      = 2'b11;
      end
      S_ORIWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // The state register already holds FETCH during reset, so only the enables need masking.
  assign pc_write      = rst_n & pc_write_raw;
  assign pc_write_cond = rst_n & pc_write_cond_raw;
  assign mem_read      = rst_n & mem_read_raw;
  assign mem_write     = rst_n & mem_write_raw;
  assign ir_write      = rst_n & ir_write_raw;
  assign reg_write     = rst_n & reg_write_raw;
  assign instr_done    = rst_n & instr_done_raw;
  assign illegal_op    = rst_n & illegal_op_raw;
  assign aluop1        = aluop[1];
  assign aluop0        = aluop[0];
  assign state         = cur_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks every instruction class, an illegal
// opcode, an asynchronous mid-instruction reset and counter wrap with CNT_W=4.
module tb_multicycle_main_control;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, pc_source;
  logic             aluop1, aluop0;
  logic [3:0]       state;
  logic             instr_done, illegal_op;
  logic [CNT_W-1:0] instr_count;

  int n_checks = 0;
  int n_fails  = 0;
  int pulses   = 0;

  multicycle_main_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluop1(aluop1), .aluop0(aluop0), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [5:0] op);
    opcode = op;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b100011;
    #2;
    check_output("reset_state", state, 0);
    check_output("reset_count", instr_count, 0);
    check_output("reset_enables", {pc_write, mem_read, ir_write, reg_write, instr_done}, 0);
    check_output("reset_alu_src_b", alu_src_b, 1);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("fetch_enables", {mem_read, ir_write, pc_write, alu_src_b}, 7'b111_01);

    // lw: 0 -> 1 -> 2 -> 3 -> 4 -> 0
    apply_stimulus(6'b100011);
    tick(); check_output("lw_decode", {state, alu_src_b}, {4'd1, 2'b11});
    tick(); check_output("lw_memadr", {state, alu_src_a, alu_src_b}, {4'd2, 1'b1, 2'b10});
    tick(); check_output("lw_memrd", {state, mem_read, i_or_d, reg_write}, {4'd3, 3'b110});
    tick(); check_output("lw_memwb", {state, reg_write, mem_to_reg, reg_dst, instr_done},
                         {4'd4, 4'b1101});
    tick(); check_output("lw_back", state, 0);
    check_output("lw_count", instr_count, 1);

    // R-type: 0 -> 1 -> 6 -> 7 -> 0
    apply_stimulus(6'b000000);
    tick(); check_output("r_decode", state, 1);
    tick(); check_output("r_exec", {state, alu_src_a, aluop1, aluop0}, {4'd6, 3'b110});
    tick(); check_output("r_rwb", {state, reg_write, reg_dst, mem_to_reg}, {4'd7, 3'b110});
    tick(); check_output("r_count", {state, instr_count}, {4'd0, 4'd2});

    // sw: 0 -> 1 -> 2 -> 5 -> 0
    apply_stimulus(6'b101011);
    tick(); tick(); check_output("sw_memadr", state, 2);
    tick(); check_output("sw_memwr", {state, mem_write, i_or_d, reg_write}, {4'd5, 3'b110});
    tick(); check_output("sw_count", {state, instr_count}, {4'd0, 4'd3});

    // beq: 0 -> 1 -> 8 -> 0
    apply_stimulus(6'b000100);
    tick(); tick();
    check_output("beq_branch", {state, aluop1, aluop0, pc_write_cond, pc_source, pc_write},
                 {4'd8, 2'b01, 1'b1, 2'b01, 1'b0});
    tick(); check_output("beq_count", {state, instr_count}, {4'd0, 4'd4});

    // ori: 0 -> 1 -> 10 -> 11 -> 0
    apply_stimulus(6'b001101);
    tick(); tick();
    check_output("ori_ex", {state, aluop1, aluop0, alu_src_b}, {4'd10, 2'b11, 2'b10});
    tick(); check_output("ori_wb", {state, reg_write, reg_dst, mem_to_reg}, {4'd11, 3'b100});
    tick(); check_output("ori_count", {state, instr_count}, {4'd0, 4'd5});

    // j: 0 -> 1 -> 9 -> 0
    apply_stimulus(6'b000010);
    tick(); tick();
    check_output("j_jump", {state, pc_source, pc_write, instr_done}, {4'd9, 2'b10, 2'b11});
    tick(); check_output("j_count", {state, instr_count}, {4'd0, 4'd6});

    // Illegal opcode: pulse in DECODE, straight back to FETCH, no retirement.
    apply_stimulus(6'b111111);
    tick(); check_output("ill_decode", {state, illegal_op, instr_done}, {4'd1, 2'b10});
    tick(); check_output("ill_back", {state, illegal_op, instr_count}, {4'd0, 1'b0, 4'd6});

    // Asynchronous reset between edges while in MEMRD.
    apply_stimulus(6'b100011);
    tick(); tick(); tick();
    check_output("abort_in_memrd", state, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_state", state, 0);
    check_output("abort_enables", {mem_read, i_or_d, ir_write, pc_write, reg_write}, 0);
    check_output("abort_count", instr_count, 0);

    // Counter wrap: 16 back-to-back jumps from a cleared count.
    apply_stimulus(6'b000010);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (instr_done) pulses++;
    end
    check_output("wrap_count_15", instr_count, 15);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (instr_done) pulses++;
    end
    check_output("wrap_count_0", {state, instr_count}, {4'd0, 4'd0});
    check_output("wrap_pulses", pulses, 16);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
